cache_fill_fsm: RTL

- Responder side of the cache/memory miss interface; the arbiter drives it.
- The arbiter presents `miss_detected` and `miss_address`. This block fetches the 16-byte block (8 words) from multi-cycle memory and streams each returned word into the cache data array.
- It writes the tag array on the last word. It holds `fsm_busy` for the whole fill, and the arbiter uses that to stall the pipeline.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/fill_word_counter.sv | 43 ++++
 rtl/cache_fill_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache block-fill logic: the fill state encoding
// and the block geometry used by cache_fill_fsm and fill_word_counter.
// A block is 16 bytes, or eight 16-bit words. A byte address splits into a
// 4-bit block offset, and bits [3:1] of that offset select the word.
// ---------------------------------------------------------------------------
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam int BLOCK_OFFSET_W  = 4;
   localparam int WORD_IDX_W      = 3;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int DATA_W          = 16;

   localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/fill_word_counter.sv
// ---------------------------------------------------------------------------
// fill_word_counter
// A wrapping word-index counter within one cache block. The top level uses
// one instance for the request index and one for the receive index.
// Priority is clear, then load, then enable. The count wraps naturally from
// the last word back to word 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous clear to word 0
//   load        in   synchronous load of load_value
//   load_value  in   starting word index
//   enable      in   advance to the next word
//   count       out  current word index
// ---------------------------------------------------------------------------
module fill_word_counter
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WORD_IDX_W-1:0] load_value,
   input  logic                  enable,
   output logic [WORD_IDX_W-1:0] count
);

   // The index wraps modulo the block size, so a fill can start mid-block
   // and still visit every word exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// This is the responder side of the cache miss interface. When the arbiter
// reports a miss, the block fetches the 16-byte block that contains the
// missing address. It issues one read request per cycle and writes each
// returned word into the cache data array. The tag array is written together
// with the last word. fsm_busy stays high for the whole fill so the arbiter
// can stall the pipeline.
//
// Optional feature, enabled when CACHE_FILL_CRITICAL_WORD_FIRST_EN is
// defined: the requests start at the missing word and wrap within the block.
// Completion then comes from a count of returned words, and the extra output
// critical_word_valid pulses with the first returned word.
//
// Ports:
//   clk                  in   system clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   miss_detected        in   level, high while a miss is pending
//   miss_address         in   byte address that missed
//   memory_data_valid    in   one pulse per returned read word, in order
//   memory_data          in   returned read data
//   fsm_busy             out  high while a fill is in progress (registered)
//   mem_read_en          out  read request, one word per cycle
//   memory_address       out  word address of the current request
//   write_data_array     out  data-array word write enable
//   write_tag_array      out  tag-array write enable, on the last word
//   fill_address         out  data-array word address for this write
//   fill_data            out  data-array write data
//   critical_word_valid  out  first returned word (optional feature only)
// ---------------------------------------------------------------------------
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MEM_LATENCY     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data,
   output logic              fsm_busy,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] fill_address,
   output logic [DATA_W-1:0] fill_data
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   ,
   output logic              critical_word_valid
`endif
);

   localparam int CNT_W = WORD_IDX_W + 1;

   // The word counters and the address math assume the geometry in the
   // package. Memory latency is a property of the system; the fill only
   // counts returned words.
   if (WORDS_PER_BLOCK != cache_pkg::WORDS_PER_BLOCK) begin : g_bad_words
      $error("cache_fill_fsm: WORDS_PER_BLOCK must match cache_pkg");
   end
   if (ADDR_W != 16) begin : g_bad_addr
      $error("cache_fill_fsm: ADDR_W must be 16");
   end
   if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
   end

   fill_state_t             state;
   logic [ADDR_W-1:0]       base;
   logic [CNT_W-1:0]        req_issued;
   logic [WORD_IDX_W-1:0]   req_idx;
   logic [WORD_IDX_W-1:0]   rcv_idx;
   logic [WORD_IDX_W-1:0]   start_idx;
   logic                    req_active;
   logic                    rcv_accept;
   logic                    last_word;
   logic                    ctr_load;
   logic                    ctr_clear;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   logic [CNT_W-1:0]        done_cnt;
`endif

   // The first word index of a fill. In critical-word-first mode it is the
   // missing word. Otherwise the fill always begins at word 0.
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign start_idx = miss_address[BLOCK_OFFSET_W-1:1];
`else
   assign start_idx = '0;
`endif

   // The counters are loaded with the start index on the edge that accepts a
   // miss. They are held at zero while no miss is pending.
   assign ctr_load   = (state == IDLE) && miss_detected;
   assign ctr_clear  = (state == IDLE) && !miss_detected;
   assign req_active = (state == FILL) && (req_issued < CNT_W'(WORDS_PER_BLOCK));
   assign rcv_accept = (state == FILL) && memory_data_valid;

   // In linear order the last word is always index 7. When the fill starts
   // mid-block the index no longer marks the end, so the returned words are
   // counted instead.
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign last_word = rcv_accept && (done_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
`else
   assign last_word = rcv_accept && (rcv_idx == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
`endif

   fill_word_counter u_req_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (ctr_clear),
      .load       (ctr_load),
      .load_value (start_idx),
      .enable     (req_active),
      .count      (req_idx)
   );

   fill_word_counter u_rcv_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (ctr_clear),
      .load       (ctr_load),
      .load_value (start_idx),
      .enable     (rcv_accept),
      .count      (rcv_idx)
   );

   // Fill sequencing. The block base is latched with the offset bits
   // stripped, so word addresses are formed by adding index*2 to the base.
   // That addition cannot carry out of the block. fsm_busy is registered
   // alongside the state so that it follows the state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fsm_busy   <= 1'b0;
         base       <= '0;
         req_issued <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
         done_cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  state      <= FILL;
                  fsm_busy   <= 1'b1;
                  base       <= miss_address & ADDR_W'(BLOCK_MASK);
                  req_issued <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                  done_cnt   <= '0;
`endif
               end
            end
            FILL: begin
               if (req_active) begin
                  req_issued <= req_issued + 1'b1;
               end
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
               if (rcv_accept) begin
                  done_cnt <= done_cnt + 1'b1;
               end
`endif
               if (last_word) begin
                  state    <= IDLE;
                  fsm_busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               fsm_busy <= 1'b0;
            end
         endcase
      end
   end

   // Request and write strobes are decoded from the registered state. Every
   // address and data output is forced to zero when its strobe is low, so an
   // idle or reset block drives nothing.
   always_comb begin
      mem_read_en      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      fill_address     = '0;
      fill_data        = '0;
      if (req_active) begin
         mem_read_en    = 1'b1;
         memory_address = base + ADDR_W'({req_idx, 1'b0});
      end
      if (rcv_accept) begin
         write_data_array = 1'b1;
         fill_address     = base + ADDR_W'({rcv_idx, 1'b0});
         fill_data        = memory_data;
      end
      write_tag_array = last_word;
   end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   // The first returned word is the one the pipeline is waiting for.
   assign critical_word_valid = rcv_accept && (done_cnt == '0);
`endif

endmodule
